// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants and the IF-stage state encoding.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    IFU_IDLE   = 2'd0,
    IFU_STREAM = 2'd1,
    IFU_HOLD   = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register that parks a fetch response while decode stalls.
module fetch_skid_buffer #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] instr_i,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] instr_o
);

  logic              valid_q;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] instr_q;

  // Load takes precedence over clear; payload only changes on load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the fetch PC, drives instruction_memory, presents {pc, instr} to decode.
// Optional misaligned-redirect trap enabled by defining IFU_ALIGN_CHECK_EN.
module instruction_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ADDR_W   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [riscv_pkg::INSTR_W-1:0] imem_instr,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         if_valid,
  input  logic                         if_ready,
  output logic [XLEN-1:0]              if_pc,
  output logic [riscv_pkg::INSTR_W-1:0] if_instr,
  output logic                         misalign_err
);

  import riscv_pkg::*;

  ifu_state_e          state_q, state_d;
  logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]     rsp_pc_q, rsp_pc_d;
  logic                halt_q, halt_d;
  logic                misalign_q;
  logic [XLEN-1:0]     redir_pc_c;
  logic                misalign_c;
  logic                stall_c;
  logic                skid_load_c, skid_clear_c;
  logic                skid_vld;
  logic [XLEN-1:0]     skid_pc;
  logic [INSTR_W-1:0]  skid_instr;

`ifdef IFU_ALIGN_CHECK_EN
  assign redir_pc_c = redirect_pc;
  assign misalign_c = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
  assign redir_pc_c = redirect_pc & ~XLEN'(3);
  assign misalign_c = 1'b0;
`endif

  // A redirect is addressed in the same cycle so its data lands one cycle later.
  assign imem_addr = redirect_valid ? redir_pc_c[ADDR_W+1:2] : fetch_pc_q[ADDR_W+1:2];

  assign if_valid = (skid_vld | (state_q == IFU_STREAM)) & ~redirect_valid;
  assign if_pc    = !if_valid ? '0 : (skid_vld ? skid_pc : rsp_pc_q);
  assign if_instr = !if_valid ? '0 : (skid_vld ? skid_instr : imem_instr);
  assign stall_c  = if_valid & ~if_ready;

  assign misalign_err = misalign_q;

  fetch_skid_buffer #(
    .PC_W   (XLEN),
    .DATA_W (INSTR_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load_c),
    .clear_i (skid_clear_c),
    .pc_i    (rsp_pc_q),
    .instr_i (imem_instr),
    .valid_o (skid_vld),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IFU_IDLE;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= '0;
      halt_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      halt_q     <= halt_d;
      misalign_q <= misalign_c;
    end
  end

  // Priority: redirect, then stall, then normal streaming (unless halted on a bad target).
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    rsp_pc_d     = rsp_pc_q;
    halt_d       = halt_q;
    skid_load_c  = 1'b0;
    skid_clear_c = 1'b0;
    if (redirect_valid) begin
      skid_clear_c = 1'b1;
      if (misalign_c) begin
        state_d = IFU_IDLE;
        halt_d  = 1'b1;
      end else begin
        state_d    = IFU_STREAM;
        rsp_pc_d   = redir_pc_c;
        fetch_pc_d = redir_pc_c + XLEN'(PC_STEP);
        halt_d     = 1'b0;
      end
    end else if (stall_c) begin
      if (state_q == IFU_STREAM) begin
        skid_load_c = 1'b1;
        state_d     = IFU_HOLD;
      end
    end else if (!halt_q) begin
      state_d      = IFU_STREAM;
      rsp_pc_d     = fetch_pc_q;
      fetch_pc_d   = fetch_pc_q + XLEN'(PC_STEP);
      skid_clear_c = 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit against a transaction-level fetch-stream model.
module tb_instruction_fetch_unit;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [XLEN-1:0]   if_pc;
  logic [31:0]       if_instr;
  logic              misalign_err;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  logic [31:0] mem [16];

  // Model: the PC decode should see, whether anything is presented, halt and trap flags.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc    = 32'h0;
  logic        m_halt  = 1'b0;
  logic        m_mis   = 1'b0;

  instruction_fetch_unit #(
    .XLEN     (XLEN),
    .ADDR_W   (ADDR_W),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0013 + (32'(i) << 20);
  end

  // Synchronous-read instruction memory with 16 words; upper address bits alias.
  always @(posedge clk) imem_instr <= mem[imem_addr];

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [31:0] idx;
    idx = (pc >> 2) % 16;
    return 32'h0000_0013 + (idx << 20);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Advance the model on each edge from the inputs that were held across it.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_pc    = RST_PC - 32'd4;
      m_halt  = 1'b0;
      m_mis   = 1'b0;
    end else if (redirect_valid) begin
`ifdef IFU_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        m_valid = 1'b0;
        m_halt  = 1'b1;
        m_mis   = 1'b1;
      end else begin
        m_valid = 1'b1;
        m_pc    = redirect_pc;
        m_halt  = 1'b0;
        m_mis   = 1'b0;
      end
`else
      m_valid = 1'b1;
      m_pc    = redirect_pc & ~32'd3;
      m_mis   = 1'b0;
`endif
    end else if (m_valid && !if_ready) begin
      m_mis = 1'b0;
    end else if (m_halt) begin
      m_valid = 1'b0;
      m_mis   = 1'b0;
    end else begin
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
      m_mis   = 1'b0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_v;
      logic [31:0] rpc;
      e_v = m_valid & ~redirect_valid;
      check("cmp_if_valid", 32'(if_valid), 32'(e_v));
      check("cmp_if_pc", if_pc, e_v ? m_pc : 32'h0);
      check("cmp_if_instr", if_instr, e_v ? exp_word(m_pc) : 32'h0);
      check("cmp_misalign", 32'(misalign_err), 32'(m_mis));
      if (redirect_valid) begin
        rpc = redirect_pc;
        check("cmp_imem_addr", 32'(imem_addr), (rpc >> 2) % 16);
      end
    end
  end

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'h0);
    next_cyc();
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_valid", 32'(if_valid), 32'h0);
    check("reset_pc", if_pc, 32'h0);
    check("reset_misalign", 32'(misalign_err), 32'h0);
    next_cyc();
    rst_n = 1'b1;

    // Streaming from reset: pc 0..28, words 0..7, no gaps
    for (int i = 0; i < 8; i++) begin
      next_cyc();
      @(negedge clk);
      check("boot_pc", if_pc, 32'(i) * 32'd4);
      check("boot_instr", if_instr, 32'h0000_0013 + (32'(i) << 20));
    end

    // Redirect to 0x10 then, while at 0x14, redirect to 0x0C
    next_cyc();
    drive(1'b1, 1'b1, 32'h10);
    @(negedge clk);
    check("redir1_squash", 32'(if_valid), 32'h0);
    next_cyc();
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("redir1_pc", if_pc, 32'h10);
    check("redir1_instr", if_instr, 32'h0040_0013);
    next_cyc();
    @(negedge clk);
    check("pre_redir2_pc", if_pc, 32'h14);
    drive(1'b1, 1'b1, 32'h0C);
    @(negedge clk);
    check("redir2_squash", 32'(if_valid), 32'h0);
    next_cyc();
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("redir2_pc", if_pc, 32'h0C);
    check("redir2_instr", if_instr, 32'h0030_0013);
    next_cyc();
    @(negedge clk);
    check("redir2_next_pc", if_pc, 32'h10);

    // Stall three cycles on pc=8, then release
    next_cyc();
    drive(1'b1, 1'b1, 32'h08);
    next_cyc();
    drive(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_pc", if_pc, 32'h08);
      check("stall_instr", if_instr, 32'h0020_0013);
      next_cyc();
    end
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("drain_pc", if_pc, 32'h08);
    next_cyc();
    @(negedge clk);
    check("post_stall_pc", if_pc, 32'h0C);
    check("post_stall_instr", if_instr, 32'h0030_0013);

    // Redirect while the skid holds pc=0x10
    next_cyc();
    drive(1'b0, 1'b0, 32'h0);
    next_cyc();
    drive(1'b0, 1'b1, 32'h30);
    @(negedge clk);
    check("skid_redir_squash", 32'(if_valid), 32'h0);
    next_cyc();
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("skid_redir_pc", if_pc, 32'h30);
    check("skid_redir_instr", if_instr, 32'h00C0_0013);

    // Stream past the end of memory: 0x40 aliases word 0
    for (int i = 0; i < 4; i++) next_cyc();
    @(negedge clk);
    check("alias_pc", if_pc, 32'h40);
    check("alias_instr", if_instr, 32'h0000_0013);

    // Reset in the middle of a stall
    next_cyc();
    drive(1'b0, 1'b0, 32'h0);
    next_cyc();
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("rst_stall_valid", 32'(if_valid), 32'h0);
    next_cyc();
    @(negedge clk);
    check("rst_restart_pc", if_pc, RST_PC);
    check("rst_restart_valid", 32'(if_valid), 32'h1);

    // Misaligned redirect target 0x06
    next_cyc();
    drive(1'b1, 1'b1, 32'h06);
    @(negedge clk);
    check("mis_squash", 32'(if_valid), 32'h0);
    next_cyc();
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
`ifdef IFU_ALIGN_CHECK_EN
    check("mis_pulse", 32'(misalign_err), 32'h1);
    check("mis_halt_valid", 32'(if_valid), 32'h0);
    next_cyc();
    @(negedge clk);
    check("mis_pulse_end", 32'(misalign_err), 32'h0);
    check("mis_still_halted", 32'(if_valid), 32'h0);
    next_cyc();
    drive(1'b1, 1'b1, 32'h08);
    next_cyc();
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("mis_resume_pc", if_pc, 32'h08);
`else
    check("mask_no_pulse", 32'(misalign_err), 32'h0);
    check("mask_pc", if_pc, 32'h04);
    check("mask_instr", if_instr, 32'h0010_0013);
`endif
    next_cyc();
    next_cyc();
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
